mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-wide data memory between NUM_REQ requesters (req 0 = wasm loader, req 1 = cpu).
//  Round-robin grant per transaction; one memory transaction in flight at a time.
//  Read-address cache absorbs the memory's repeated-address read rule; a timeout bounds stalled reads.
//  Sits between the requesters and the memory's addr/data_in/data_out/read_en/write_en/ready pins.
// PARAMETERS
//  NUM_REQ     2    number of requesters (>=2)
//  ADDR_W      32   address width
//  DATA_W      8    data width
//  TIMEOUT     64   cycles RD waits for mem_ready before err completion (>=2)
// PORTS
//  clk           in   1                 clock, all state on posedge
//  rst_n         in   1                 asynchronous active-low reset
//  req_rd        in   NUM_REQ           per-requester read request, held until its req_ready
//  req_wr        in   NUM_REQ           per-requester write request, held until its req_ready
//  req_addr      in   NUM_REQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata     in   NUM_REQ*DATA_W    packed write data
//  req_ready     out  NUM_REQ           one-cycle completion pulse to granted requester
//  req_err       out  1                 high with req_ready when read timed out
//  req_rdata     out  DATA_W            read data, valid with req_ready, held until next completion
//  mem_addr      out  ADDR_W            to memory addr
//  mem_wdata     out  DATA_W            to memory data_in
//  mem_read_en   out  1                 to memory read enable
//  mem_write_en  out  1                 to memory write enable
//  mem_rdata     in   DATA_W            from memory data_out
//  mem_ready     in   1                 from memory ready (one-cycle pulse)
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, state IDLE, cache invalid, rr pointer 0, timeout count 0.
//  All outputs registered. States: IDLE, RD, WR, RESP.
//  IDLE: pending_i = req_rd[i]|req_wr[i]. Grant first pending at/after ptr (wrap at NUM_REQ).
//   Latch grant, addr, wdata. req_rd&req_wr together is illegal; treated as write.
//   Write -> WR. Read with cache_valid && addr==cache_addr -> RESP with cache_data (no mem access).
//   Other read -> RD. No pending -> stay IDLE.
//  RD: mem_read_en=1, mem_addr held. On mem_ready: rdata<=mem_rdata, cache_addr/data<=addr/data,
//   cache_valid<=1, mem_read_en<=0 -> RESP.
//   Timeout count reaches TIMEOUT first: mem_read_en<=0, rdata unchanged, err -> RESP.
//  WR: mem_write_en=1 with mem_addr/mem_wdata for exactly one cycle; cache_valid<=0 (any address) -> RESP.
//  RESP: req_ready[grant]=1 and req_err for one cycle; ptr<=grant+1 (wrap); -> IDLE.
//  Latency from grant cycle T: hit ready at T+1; write ready at T+2; read miss ready at T+3 with 1-cycle memory.
//  mem_ready outside RD is ignored. mem_read_en and mem_write_en are never both high.
//  Requester deasserting mid-transaction: transaction still completes and pulses ready.
//  Requests arriving during a transaction wait; a requester is never granted twice in a row while another is pending.
//  Reset mid-transaction: enables drop immediately, no req_ready issued, cache invalid.
// STRUCTURE
//  mem_arb_defs.vh: state encodings (IDLE/RD/WR/RESP), defaults for NUM_REQ/TIMEOUT.
//  Sub-module rr_arbiter: combinational round-robin pick (pending, ptr) -> grant index + any.
//  Top holds FSM, address/data latches, read cache, timeout counter.
// TESTING
//  Reset mid-RD (rst_n low while mem_read_en=1) -> mem_read_en 0 same cycle, no req_ready, later read of same addr misses.
//  Req0 writes 0x1E to 0xAB, then req1 reads 0xAB -> mem_write_en one cycle, req_ready[1] with req_rdata 0x1E, req_err 0.
//  Req1 reads 0x10 twice back-to-back -> one mem_read_en burst; second ready 1 cycle after grant, same data.
//  Both requesters continuously read distinct addrs -> grants alternate 0,1,0,1; none starved over 20 transactions.
//  Read 0x05, write 0x05=0x77, read 0x05 -> cache invalidated, third read goes to memory, returns 0x77.
//  Read addr 0 after reset (memory never responds) -> req_ready with req_err=1 after TIMEOUT cycles; next request served.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the byte-wide memory arbiter.
// Holds the FSM state encoding and the round-robin pointer advance helper.
package mem_arbiter_pkg;

    localparam int NUM_REQ_DEF = 2;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first pending requester at or after ptr,
// wrapping at NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any
);

    logic [IDX_W:0] cand;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit keeps ptr+k from overflowing before the wrap.
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!any && pending[cand[IDX_W-1:0]]) begin
                any   = 1'b1;
                grant = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide memory between NUM_REQ requesters, one transaction at a time,
// with a single-entry read cache and a bounded wait on memory read responses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_rd,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      req_err,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_read_en,
    output logic                      mem_write_en,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ready
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                cache_valid_q, cache_valid_d;
    logic [ADDR_W-1:0]   cache_addr_q, cache_addr_d;
    logic [DATA_W-1:0]   cache_data_q, cache_data_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_read_en_q, mem_read_en_d;
    logic                mem_write_en_q, mem_write_en_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic                req_err_q, req_err_d;
    logic [DATA_W-1:0]   req_rdata_q, req_rdata_d;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]  pending;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    assign pending = req_rd | req_wr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .pending (pending),
        .ptr     (ptr_q),
        .grant   (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        ptr_d          = ptr_q;
        tmo_d          = tmo_q;
        cache_valid_d  = cache_valid_q;
        cache_addr_d   = cache_addr_q;
        cache_data_d   = cache_data_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_read_en_d  = 1'b0;
        mem_write_en_d = 1'b0;
        req_ready_d    = '0;
        req_err_d      = 1'b0;
        req_rdata_d    = req_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d     = pick_idx;
                    mem_addr_d  = addr_arr[pick_idx];
                    mem_wdata_d = wdata_arr[pick_idx];
                    // rd and wr together is illegal; the write wins.
                    if (req_wr[pick_idx]) begin
                        state_d        = ST_WR;
                        mem_write_en_d = 1'b1;
                    end else if (cache_valid_q && addr_arr[pick_idx] == cache_addr_q) begin
                        state_d               = ST_RESP;
                        req_ready_d[pick_idx] = 1'b1;
                        req_rdata_d           = cache_data_q;
                    end else begin
                        state_d       = ST_RD;
                        mem_read_en_d = 1'b1;
                        tmo_d         = '0;
                    end
                end
            end
            ST_RD: begin
                if (mem_ready) begin
                    req_rdata_d          = mem_rdata;
                    cache_valid_d        = 1'b1;
                    cache_addr_d         = mem_addr_q;
                    cache_data_d         = mem_rdata;
                    req_ready_d[grant_q] = 1'b1;
                    state_d              = ST_RESP;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    req_err_d            = 1'b1;
                    req_ready_d[grant_q] = 1'b1;
                    state_d              = ST_RESP;
                end else begin
                    tmo_d         = tmo_q + 1'b1;
                    mem_read_en_d = 1'b1;
                end
            end
            ST_WR: begin
                // A single-entry cache cannot tell if the write aliases it; drop it.
                cache_valid_d        = 1'b0;
                req_ready_d[grant_q] = 1'b1;
                state_d              = ST_RESP;
            end
            ST_RESP: begin
                ptr_d   = IDX_W'(next_idx(int'(grant_q), NUM_REQ));
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            ptr_q          <= '0;
            tmo_q          <= '0;
            cache_valid_q  <= 1'b0;
            cache_addr_q   <= '0;
            cache_data_q   <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            req_ready_q    <= '0;
            req_err_q      <= 1'b0;
            req_rdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            ptr_q          <= ptr_d;
            tmo_q          <= tmo_d;
            cache_valid_q  <= cache_valid_d;
            cache_addr_q   <= cache_addr_d;
            cache_data_q   <= cache_data_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_write_en_q <= mem_write_en_d;
            req_ready_q    <= req_ready_d;
            req_err_q      <= req_err_d;
            req_rdata_q    <= req_rdata_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign req_err      = req_err_q;
    assign req_rdata    = req_rdata_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_read_en  = mem_read_en_q;
    assign mem_write_en = mem_write_en_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte memory model answering reads one cycle after it
// sees read_en, a transaction vector table, and hand-written corner sequences.
module tb_mem_arbiter;

    localparam int NR  = 2;
    localparam int AW  = 32;
    localparam int DW  = 8;
    localparam int TMO = 64;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_rd;
    logic [NR-1:0]    req_wr;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic             req_err;
    logic [DW-1:0]    req_rdata;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_read_en;
    logic             mem_write_en;
    logic [DW-1:0]    mem_rdata;
    logic             mem_ready;

    mem_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .req_err      (req_err),
        .req_rdata    (req_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    logic [7:0] mem_arr [256];
    logic       mem_on;
    logic       pend;
    logic       rd_en_prev;
    int         rd_bursts = 0;
    int         wr_cycles = 0;

    typedef struct {
        int          id;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        int          lat;
        int          rdb;
        int          wrb;
    } vec_t;

    vec_t vecs [14];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mem_init(input logic [7:0] a);
        logic [7:0] r;
        r = a * 8'd3 + 8'd1;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: writes land on the negedge of the write cycle; a read is
    // answered with a one-cycle mem_ready in the cycle after read_en is seen.
    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = mem_init(8'(i));
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        pend       = 1'b0;
        rd_en_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend       = 1'b0;
                mem_ready  = 1'b0;
                rd_en_prev = 1'b0;
            end else begin
                if (mem_read_en || mem_write_en)
                    check("en_excl", {31'd0, mem_read_en & mem_write_en}, 32'd0);
                if (mem_write_en) begin
                    mem_arr[mem_addr[7:0]] = mem_wdata;
                    wr_cycles++;
                end
                if (mem_read_en && !rd_en_prev) rd_bursts++;
                rd_en_prev = mem_read_en;
                mem_ready  = 1'b0;
                if (pend) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_arr[mem_addr[7:0]];
                    pend      = 1'b0;
                end else if (mem_read_en && mem_on) begin
                    pend = 1'b1;
                end
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a later idle negedge.
    task automatic run_txn(input string tag, input int id, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [7:0] wdata,
                           input logic [7:0] exp_rd, input int exp_lat, input int exp_rdb,
                           input int exp_wrb, input logic exp_err, input logic drop_early);
        int   lat;
        int   b0;
        int   w0;
        logic got;
        logic is_read;
        logic [NR-1:0] exp_ready;
        is_read = rd & ~wr;
        req_rd[id] = rd;
        req_wr[id] = wr;
        req_addr[id*AW +: AW]  = addr;
        req_wdata[id*DW +: DW] = wdata;
        if (is_read) exp_q.push_back(exp_rd);
        b0  = rd_bursts;
        w0  = wr_cycles;
        lat = 0;
        got = 1'b0;
        while (!got && lat < TMO + 10) begin
            @(negedge clk);
            lat++;
            if (req_ready != '0) got = 1'b1;
            else if (drop_early && lat == 1) begin
                req_rd[id] = 1'b0;
                req_wr[id] = 1'b0;
            end
        end
        check({tag, "_done"}, {31'd0, got}, 32'd1);
        exp_ready = '0;
        exp_ready[id] = 1'b1;
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
        if (exp_lat < 0)
            check({tag, "_tmo_lat"}, {31'd0, (lat >= TMO && lat <= TMO + 2)}, 32'd1);
        else
            check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_err"}, {31'd0, req_err}, {31'd0, exp_err});
        if (is_read && exp_q.size() > 0)
            check({tag, "_rdata"}, 32'(req_rdata), 32'(exp_q.pop_front()));
        check({tag, "_rd_bursts"}, rd_bursts - b0, exp_rdb);
        check({tag, "_wr_cycles"}, wr_cycles - w0, exp_wrb);
        req_rd[id] = 1'b0;
        req_wr[id] = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        logic       seen;
        int         done;
        int         cyc;
        int         who;
        int         prev;
        int         cnt [NR];
        logic [7:0] k [NR];

        rst_n     = 1'b0;
        req_rd    = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_on    = 1'b1;

        vecs[0]  = '{0, 1'b0, 1'b1, 32'h0000_00AB, 8'h1E, 8'h00, 2, 0, 1};
        vecs[1]  = '{1, 1'b1, 1'b0, 32'h0000_00AB, 8'h00, 8'h1E, 3, 1, 0};
        vecs[2]  = '{1, 1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'h31, 3, 1, 0};
        vecs[3]  = '{1, 1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'h31, 1, 0, 0};
        vecs[4]  = '{0, 1'b1, 1'b0, 32'h0000_0005, 8'h00, 8'h10, 3, 1, 0};
        vecs[5]  = '{0, 1'b1, 1'b0, 32'h0000_0005, 8'h00, 8'h10, 1, 0, 0};
        vecs[6]  = '{1, 1'b0, 1'b1, 32'h0000_0005, 8'h77, 8'h00, 2, 0, 1};
        vecs[7]  = '{0, 1'b1, 1'b0, 32'h0000_0005, 8'h00, 8'h77, 3, 1, 0};
        vecs[8]  = '{0, 1'b1, 1'b0, 32'h1234_5610, 8'h00, 8'h31, 3, 1, 0};
        vecs[9]  = '{0, 1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'h31, 3, 1, 0};
        vecs[10] = '{1, 1'b1, 1'b1, 32'h0000_0020, 8'h33, 8'h00, 2, 0, 1};
        vecs[11] = '{0, 1'b1, 1'b0, 32'h0000_0020, 8'h00, 8'h33, 3, 1, 0};
        vecs[12] = '{0, 1'b0, 1'b1, 32'h0000_0099, 8'h44, 8'h00, 2, 0, 1};
        vecs[13] = '{0, 1'b1, 1'b0, 32'h0000_0020, 8'h00, 8'h33, 3, 1, 0};

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_err", {31'd0, req_err}, 32'd0);
        check("rst_rdata", 32'(req_rdata), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rd_en", {31'd0, mem_read_en}, 32'd0);
        check("rst_wr_en", {31'd0, mem_write_en}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Memory silent: the read must end with an error, rdata untouched.
        mem_on = 1'b0;
        run_txn("tmo", 0, 1'b1, 1'b0, 32'h0, 8'h00, 8'h00, -1, 1, 0, 1'b1, 1'b0);
        mem_on = 1'b1;
        run_txn("after_tmo", 1, 1'b1, 1'b0, 32'h0, 8'h00, 8'h01, 3, 1, 0, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp_rd, vecs[i].lat, vecs[i].rdb, vecs[i].wrb,
                    1'b0, 1'b0);
        end

        // Requester lets go one cycle into the read; it still completes.
        run_txn("drop", 1, 1'b1, 1'b0, 32'h44, 8'h00, 8'hCD, 3, 1, 0, 1'b0, 1'b1);

        // Both requesters read distinct addresses back to back.
        k[0] = 8'h40;
        k[1] = 8'h80;
        cnt[0] = 0;
        cnt[1] = 0;
        req_rd = 2'b11;
        req_addr[0 +: AW]  = {24'd0, k[0]};
        req_addr[AW +: AW] = {24'd0, k[1]};
        done = 0;
        cyc  = 0;
        prev = -1;
        while (done < 20 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin
                who = req_ready[1] ? 1 : 0;
                check("rr_onehot", {31'd0, (req_ready == 2'b01 || req_ready == 2'b10)}, 32'd1);
                if (prev < 0) check("rr_first", who, 0);
                else check("rr_alt", who, 1 - prev);
                check("rr_rdata", 32'(req_rdata), 32'(mem_init(k[who])));
                cnt[who]++;
                k[who] = k[who] + 8'd1;
                req_addr[who*AW +: AW] = {24'd0, k[who]};
                prev = who;
                done++;
            end
        end
        req_rd = '0;
        check("rr_done", done, 20);
        check("rr_cnt0", cnt[0], 10);
        check("rr_cnt1", cnt[1], 10);
        @(negedge clk);

        // Cache 0x66, stall a read of 0x99, reset in the middle of it.
        run_txn("pre_rst", 0, 1'b1, 1'b0, 32'h66, 8'h00, 8'h33, 3, 1, 0, 1'b0, 1'b0);
        mem_on = 1'b0;
        req_rd[1] = 1'b1;
        req_addr[AW +: AW] = 32'h99;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_read_en) seen = 1'b1;
        end
        check("rst_rd_started", {31'd0, seen}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", {31'd0, mem_read_en}, 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        req_rd   = '0;
        req_addr = '0;
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_no_ready", 32'(req_ready), 32'd0);
        end
        rst_n  = 1'b1;
        mem_on = 1'b1;
        @(negedge clk);
        run_txn("post_rst", 0, 1'b1, 1'b0, 32'h66, 8'h00, 8'h33, 3, 1, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
